// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier that borrows the shared ALU adder.
// Returns the low WIDTH bits of mcand*mplier with a start/busy/done handshake.
module alu_mul_seq #(
  parameter int          WIDTH   = 64,
  parameter logic [3:0]  ADD_CTL = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_zero,
  output logic [WIDTH-1:0] alu_a_out,
  output logic [WIDTH-1:0] alu_b_out,
  output logic [3:0]       alu_control_out,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic             alu_zero_in
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLAG} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             prod_zero_q, prod_zero_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      prod_zero_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      prod_zero_q <= prod_zero_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    prod_zero_d = prod_zero_q;
    done_d      = 1'b0;
    alu_a_out   = '0;
    alu_b_out   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = mcand_in;
          mplier_d = mplier_in;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        alu_a_out = acc_q;
        alu_b_out = mplier_q[0] ? mcand_q : '0;
        acc_d     = alu_result_in;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        // Stop early once no set multiplier bits remain.
        if ((mplier_q >> 1) == '0 || cnt_q == CW'(WIDTH - 1))
          state_d = FLAG;
      end
      FLAG: begin
        // ALU computes acc+0 so its zero flag reflects the final product.
        alu_a_out   = acc_q;
        product_d   = acc_q;
        prod_zero_d = alu_zero_in;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q == RUN) || (state_q == FLAG);
  assign done            = done_q;
  assign product         = product_q;
  assign prod_zero       = prod_zero_q;
  assign alu_control_out = ADD_CTL;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative shift-and-add multiplier in the execute stage that drives the shared ALU rather than containing its own adder. It sits on the operand/control side of the ALU: it sources `a_in`/`b_in`/`alu_control` and consumes `alu_result`/`zero`. It returns the low WIDTH bits of the product (LEGv8 MUL semantics) with a start/busy/done handshake. The execute-stage mux hands the ALU to this block while `busy` is high.

## Interface
- WIDTH, default `WORD (64): operand, product and ALU datapath width.
- ADD_CTL, default 4'b0010: ALU control code for add.

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mcand_in  input  WIDTH  multiplicand, captured on accepted start
- mplier_in  input  WIDTH  multiplier, captured on accepted start
- busy  output  1  high in RUN and FLAG
- done  output  1  one-cycle registered pulse; product/prod_zero valid from this cycle
- product  output  WIDTH  registered result, held until next completion
- prod_zero  output  1  registered; 1 iff product == 0
- alu_a_out  output  WIDTH  to ALU a_in
- alu_b_out  output  WIDTH  to ALU b_in
- alu_control_out  output  4  to ALU alu_control; always ADD_CTL
- alu_result_in  input  WIDTH  from ALU alu_result (combinational)
- alu_zero_in  input  1  from ALU zero

## Operation
- Registers: state, acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt ($clog2(WIDTH) bits), product, prod_zero, done.
- Reset: state=IDLE; acc, mcand, mplier, cnt, product = 0; prod_zero=0; done=0.
- IDLE: drive alu_a_out=0, alu_b_out=0. If start: acc<=0, mcand<=mcand_in, mplier<=mplier_in, cnt<=0, go RUN.
- RUN: drive alu_a_out=acc, alu_b_out = mplier[0] ? mcand : 0. Each edge:
  - acc<=alu_result_in
  - mcand<=mcand<<1
  - mplier<=mplier>>1
  - cnt<=cnt+1
- RUN exit to FLAG when (mplier>>1)==0 or cnt==WIDTH-1; otherwise stay in RUN.
- FLAG: drive alu_a_out=acc, alu_b_out=0. On edge: product<=acc, prod_zero<=alu_zero_in, done<=1, go IDLE.
- done is cleared on every edge that is not a FLAG->IDLE transition.
- Arithmetic: all sums wrap mod 2^WIDTH. Bits shifted out of mcand are discarded. The product is the unsigned/two's-complement low half (identical for the low WIDTH bits).
- start while busy is ignored; no queueing.
- start high in the done cycle (state IDLE) is accepted normally. product holds its old value until the new FLAG edge.
- mcand_in/mplier_in are don't-care except on an accepted start edge.

## Timing
- RUN length R = max(1, index of highest set bit of mplier_in + 1); 1 ≤ R ≤ WIDTH.
- Start accepted at edge k. RUN occupies edges k+1..k+R, FLAG occupies edge k+R+1, and done is high during the cycle after edge k+R+1. Latency = R+1 edges.
- busy is combinational from state: high from the cycle after edge k through the FLAG cycle, and low in the done cycle.
- alu_*_out are combinational from state/regs only. There is no combinational path from start to ALU outputs.
- Reset asserted mid-operation: immediate return to IDLE with all registers at reset values. No done pulse is produced, and a partial product is never exposed.
- Back-to-back operation: minimum spacing between accepted starts is R+2 cycles.

## Test plan
- Reset, then start with mcand=5, mplier=3 → busy for 3 cycles; done pulses once 3 edges after the start edge; product=15, prod_zero=0; alu_control_out=4'b0010 throughout.
- mcand=0x1234, mplier=0 → R=1, done at 2 edges after start; product=0, prod_zero=1.
- mcand=mplier=0xFFFF_FFFF_FFFF_FFFF (WIDTH=64) → R=64, done at 65 edges; product=1, prod_zero=0.
- mcand=0x8000_0000_0000_0000, mplier=2 → wrap to product=0, prod_zero=1, done at 3 edges.
- Start 7×9, pulse start again on edges 1–2 of RUN → ignored, single done, product=63. Then start 2×2 in the done cycle → accepted, product=4 after 3 edges; done pulses twice total.
- Start 6×0xFF, assert reset during RUN edge 4 → done never pulses; product=0, busy=0, state IDLE. A new start of 6×7 after reset release → product=42.
